// File: rtl/xvec2_vec_serializer.sv
// -----------------------------------------------------------------------------
// xvec2_vec_serializer
//
// Purpose:
//   Accepts one packed VEC_SIZE x XPR_LEN vector from the vector ALU and
//   returns it lane by lane on a scalar XPR_LEN port. Valid/ready handshakes
//   are used on both sides. One vector is buffered. A new vector can be
//   accepted in the same cycle as the final lane leaves, so a stream of
//   vectors runs at one lane per cycle with no bubble.
//
// Configuration:
//   XVEC2_SER_MASK_EN : when defined, in_mask selects which lanes are
//                       emitted. Disabled lanes are skipped, and an all-zero
//                       mask is consumed with no output. When undefined,
//                       in_mask is ignored and all lanes are emitted.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   packed vector offered
//   in_ready   out  vector can be accepted this cycle
//   in_vec     in   packed vector, lane i = in_vec[i*XPR_LEN +: XPR_LEN]
//   in_mask    in   per-lane enable (only used with XVEC2_SER_MASK_EN)
//   out_valid  out  scalar lane valid
//   out_ready  in   consumer takes the lane
//   out_data   out  lane value
//   out_lane   out  index of the lane on out_data
//   out_last   out  final enabled lane of the current vector
//   busy       out  a vector is held
//   sent_cnt   out  lanes transferred since reset, saturating at all-ones
// -----------------------------------------------------------------------------
module xvec2_vec_serializer #(
    parameter int VEC_SIZE = 4,
    parameter int XPR_LEN  = 32,
    parameter int CNT_W    = 16
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [VEC_SIZE*XPR_LEN-1:0]   in_vec,
    input  logic [VEC_SIZE-1:0]           in_mask,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [XPR_LEN-1:0]            out_data,
    output logic [$clog2(VEC_SIZE)-1:0]   out_lane,
    output logic                          out_last,
    output logic                          busy,
    output logic [CNT_W-1:0]              sent_cnt
);

    localparam int LANE_W = $clog2(VEC_SIZE);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    logic [0:0]                  state_q;
    logic [VEC_SIZE*XPR_LEN-1:0] vec_q;
    logic [LANE_W-1:0]           lane_q;
    logic [CNT_W-1:0]            cnt_q;

    // Enabled lanes of the held vector and of the vector being offered.
    logic [VEC_SIZE-1:0] en_q;
    logic [VEC_SIZE-1:0] en_in;

`ifdef XVEC2_SER_MASK_EN
    logic [VEC_SIZE-1:0] mask_q;
    assign en_q  = mask_q;
    assign en_in = in_mask;
`else
    assign en_q  = '1;
    assign en_in = '1;
    logic unused_mask;
    assign unused_mask = ^in_mask;
`endif

    // Unpacked view of the buffer, so the lane mux is a plain array index.
    logic [XPR_LEN-1:0] lanes [VEC_SIZE];
    for (genvar g = 0; g < VEC_SIZE; g++) begin : g_lanes
        assign lanes[g] = vec_q[g*XPR_LEN +: XPR_LEN];
    end

    // Next enabled lane above the current one and first enabled lane of the
    // incoming vector. Both loops scan downward, so the last hit is the lowest.
    logic [LANE_W-1:0] next_lane;
    logic              has_next;
    logic [LANE_W-1:0] first_lane;
    logic              any_in;

    // NOTE: every signal driven here gets a default first; a path that left
    // one unassigned would infer a latch.
    always_comb begin
        next_lane  = lane_q;
        has_next   = 1'b0;
        first_lane = '0;
        any_in     = 1'b0;
        for (int i = VEC_SIZE - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(lane_q))) begin
                next_lane = LANE_W'(i);
                has_next  = 1'b1;
            end
            if (en_in[i]) begin
                first_lane = LANE_W'(i);
                any_in     = 1'b1;
            end
        end
    end

    logic send;
    logic out_fire;
    logic accept;

    assign send     = (state_q == ST_SEND);
    assign out_fire = send & out_ready;
    assign in_ready = ~send | (out_fire & ~has_next);
    assign accept   = in_valid & in_ready;

    assign out_valid = send;
    assign busy      = send;
    assign out_last  = send & ~has_next;
    assign out_lane  = send ? lane_q : '0;
    assign out_data  = send ? lanes[lane_q] : '0;
    assign sent_cnt  = cnt_q;

    // NOTE: the vector buffer is reset along with the control state because
    // the reset contract defines its contents as zero; it is a single
    // register, not a memory, so the reset is inexpensive.
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            vec_q   <= '0;
            lane_q  <= '0;
            cnt_q   <= '0;
`ifdef XVEC2_SER_MASK_EN
            mask_q  <= '0;
`endif
        end else begin
            if (out_fire && (cnt_q != '1)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Accept has priority: it can only coincide with the final lane
            // leaving, which hands the buffer straight to the new vector.
            if (accept) begin
                vec_q   <= in_vec;
`ifdef XVEC2_SER_MASK_EN
                mask_q  <= in_mask;
`endif
                lane_q  <= first_lane;
                // An all-zero mask is consumed without producing output.
                state_q <= any_in ? ST_SEND : ST_IDLE;
            end else if (out_fire) begin
                if (has_next) begin
                    lane_q <= next_lane;
                end else begin
                    lane_q  <= '0;
                    state_q <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_xvec2_vec_serializer.sv
module tb_xvec2_vec_serializer;

    localparam int VS = 4;
    localparam int XL = 32;

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              in_valid = 1'b0;
    logic              out_ready = 1'b0;
    logic [VS*XL-1:0]  in_vec = '0;
    logic [VS-1:0]     in_mask = '0;

    logic              in_ready, out_valid, out_last, busy;
    logic [XL-1:0]     out_data;
    logic [1:0]        out_lane;
    logic [15:0]       sent_cnt;

    logic              s_in_ready, s_out_valid, s_out_last, s_busy;
    logic [XL-1:0]     s_out_data;
    logic [1:0]        s_out_lane;
    logic [3:0]        s_sent_cnt;

    xvec2_vec_serializer #(.VEC_SIZE(VS), .XPR_LEN(XL), .CNT_W(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_mask(in_mask),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_lane(out_lane), .out_last(out_last), .busy(busy), .sent_cnt(sent_cnt)
    );

    xvec2_vec_serializer #(.VEC_SIZE(VS), .XPR_LEN(XL), .CNT_W(4)) dut_sat (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_vec(in_vec), .in_mask(in_mask),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .out_lane(s_out_lane), .out_last(s_out_last), .busy(s_busy), .sent_cnt(s_sent_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int total = 0;   // lanes transferred since last reset (unsaturated)

    typedef struct {
        logic [VS*XL-1:0] vec;
        logic [VS-1:0]    mask;
        logic [VS-1:0]    exp_en;   // lanes expected on the out port
    } vec_row_t;

    typedef struct {
        logic [XL-1:0] data;
        logic [1:0]    lane;
        logic          last;
    } lane_t;

    lane_t sb[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    function automatic logic [VS-1:0] eff_mask(input logic [VS-1:0] m);
`ifdef XVEC2_SER_MASK_EN
        return m;
`else
        return (m | ~m);
`endif
    endfunction

    // Reference: a vector becomes the list of its enabled lanes in ascending
    // order, the highest one marked last.
    task automatic push_vec(input logic [VS*XL-1:0] v, input logic [VS-1:0] m);
        logic [VS-1:0] en;
        int            hi;
        lane_t         e;
        en = eff_mask(m);
        hi = -1;
        for (int i = 0; i < VS; i++) if (en[i]) hi = i;
        for (int i = 0; i < VS; i++) begin
            if (en[i]) begin
                e.data = v[i*XL +: XL];
                e.lane = 2'(i);
                e.last = (i == hi);
                sb.push_back(e);
            end
        end
    endtask

    task automatic run_row(input vec_row_t r, input int idx);
        int hi;
        hi = -1;
        for (int i = 0; i < VS; i++) if (r.exp_en[i]) hi = i;
        @(negedge clk);
        in_vec = r.vec; in_mask = r.mask; in_valid = 1'b1; out_ready = 1'b1;
        #1 check($sformatf("row%0d in_ready", idx), 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < VS; i++) begin
            if (r.exp_en[i]) begin
                check($sformatf("row%0d lane%0d valid", idx, i), 64'(out_valid), 64'd1);
                check($sformatf("row%0d lane%0d data", idx, i), 64'(out_data), 64'(r.vec[i*XL +: XL]));
                check($sformatf("row%0d lane%0d idx", idx, i), 64'(out_lane), 64'(i));
                check($sformatf("row%0d lane%0d last", idx, i), 64'(out_last), 64'(i == hi));
                total++;
                @(negedge clk);
            end
        end
        check($sformatf("row%0d done valid", idx), 64'(out_valid), 64'd0);
        check($sformatf("row%0d done in_ready", idx), 64'(in_ready), 64'd1);
        check($sformatf("row%0d done busy", idx), 64'(busy), 64'd0);
        check($sformatf("row%0d sent_cnt", idx), 64'(sent_cnt), 64'(sat(total, 16)));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        total = 0;
        sb.delete();
    endtask

    function automatic logic [VS*XL-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    vec_row_t rows [6];

    initial begin
        logic [VS*XL-1:0] va, vb;
        int n_acc, guard;
        logic pend;
        logic exp_ready;

        // ---- reset state ----
        #1;
        check("rst out_valid", 64'(out_valid), 64'd0);
        check("rst in_ready", 64'(in_ready), 64'd1);
        check("rst busy", 64'(busy), 64'd0);
        check("rst sent_cnt", 64'(sent_cnt), 64'd0);
        check("rst out_data", 64'(out_data), 64'd0);
        check("rst out_lane", 64'(out_lane), 64'd0);
        check("rst out_last", 64'(out_last), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // ---- table-driven vectors (exp_en given for the masked build) ----
        rows[0] = '{{32'h4, 32'h3, 32'h2, 32'h1}, 4'b1111, 4'b1111};
        rows[1] = '{{32'hDEAD0003, 32'hBEEF0002, 32'hCAFE0001, 32'hF00D0000}, 4'b1010, 4'b1010};
        rows[2] = '{{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444}, 4'b0000, 4'b0000};
        rows[3] = '{{32'hA5A5A5A5, 32'h5A5A5A5A, 32'hFFFFFFFF, 32'h00000001}, 4'b0001, 4'b0001};
        rows[4] = '{{32'h80000000, 32'h7FFFFFFF, 32'h0000FFFF, 32'hFFFF0000}, 4'b1000, 4'b1000};
        rows[5] = '{{32'h01234567, 32'h89ABCDEF, 32'h13579BDF, 32'h2468ACE0}, 4'b0110, 4'b0110};
`ifndef XVEC2_SER_MASK_EN
        for (int i = 0; i < 6; i++) rows[i].exp_en = 4'b1111;
`endif
        for (int i = 0; i < 6; i++) run_row(rows[i], i);

        // ---- backpressure on lane 1 ----
        @(negedge clk);
        in_vec = {32'h4, 32'h3, 32'h2, 32'h1}; in_mask = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        check("bp lane0 data", 64'(out_data), 64'h1);
        @(negedge clk);
        check("bp lane1 data", 64'(out_data), 64'h2);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("bp hold%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("bp hold%0d data", k), 64'(out_data), 64'h2);
            check($sformatf("bp hold%0d lane", k), 64'(out_lane), 64'd1);
            check($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp resume data", 64'(out_data), 64'h3);
        check("bp resume lane", 64'(out_lane), 64'd2);
        @(negedge clk);
        check("bp lane3 data", 64'(out_data), 64'h4);
        check("bp lane3 last", 64'(out_last), 64'd1);
        @(negedge clk);
        check("bp done valid", 64'(out_valid), 64'd0);
        total += 4;
        check("bp sent_cnt", 64'(sent_cnt), 64'(sat(total, 16)));

        // ---- back-to-back: 8 lanes in 8 cycles ----
        va = {32'h8, 32'h7, 32'h6, 32'h5};
        vb = {32'hD, 32'hC, 32'hB, 32'hA};
        @(negedge clk);
        in_vec = va; in_mask = 4'hF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("b2b k%0d valid", k), 64'(out_valid), 64'd1);
            check($sformatf("b2b k%0d data", k), 64'(out_data),
                  64'((k < 4) ? va[k*XL +: XL] : vb[(k-4)*XL +: XL]));
            check($sformatf("b2b k%0d lane", k), 64'(out_lane), 64'(k % 4));
            check($sformatf("b2b k%0d last", k), 64'(out_last), 64'((k % 4) == 3));
            if (k == 3) begin
                in_vec = vb; in_valid = 1'b1;
                #1 check("b2b in_ready on last", 64'(in_ready), 64'd1);
            end
            if (k == 4) in_valid = 1'b0;
            @(negedge clk);
        end
        check("b2b done valid", 64'(out_valid), 64'd0);
        total += 8;
        check("b2b sent_cnt", 64'(sent_cnt), 64'(sat(total, 16)));

        // ---- reset asserted mid-vector ----
        @(negedge clk);
        in_vec = va; in_mask = 4'hF; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("midrst pre busy", 64'(busy), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst out_valid", 64'(out_valid), 64'd0);
        check("midrst busy", 64'(busy), 64'd0);
        check("midrst in_ready", 64'(in_ready), 64'd1);
        check("midrst sent_cnt", 64'(sent_cnt), 64'd0);
        check("midrst out_last", 64'(out_last), 64'd0);
        @(negedge clk);
        reset_n = 1'b1;
        total = 0;
        @(negedge clk);
        check("midrst after valid", 64'(out_valid), 64'd0);

        // ---- saturation: 5 vectors streamed, 20 lanes ----
        in_vec = rand_vec(); in_mask = 4'hF; in_valid = 1'b1; out_ready = 1'b1;
        n_acc = 0; guard = 0;
        while (n_acc < 5 && guard < 100) begin
            #1;
            if (in_ready) n_acc++;
            @(negedge clk);
            if (n_acc == 5) in_valid = 1'b0;
            guard++;
        end
        check("sat stream accepted", 64'(n_acc), 64'd5);
        repeat (8) @(negedge clk);
        check("sat cnt4", 64'(s_sent_cnt), 64'd15);
        check("sat cnt16", 64'(sent_cnt), 64'd20);
        check("sat idle", 64'(out_valid), 64'd0);

        // ---- randomized traffic against the lane-list model ----
        do_reset();
        pend = 1'b0;
        for (int c = 0; c < 400; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            if (!pend) begin
                in_valid = $urandom_range(0, 1) == 1;
                in_vec   = rand_vec();
                in_mask  = 4'($urandom_range(0, 15));
            end
            #1;
            exp_ready = (sb.size() == 0) || (out_ready && sb.size() == 1);
            check("rnd in_ready", 64'(in_ready), 64'(exp_ready));
            check("rnd out_valid", 64'(out_valid), 64'(sb.size() != 0));
            check("rnd busy", 64'(busy), 64'(sb.size() != 0));
            check("rnd sent_cnt", 64'(sent_cnt), 64'(sat(total, 16)));
            check("rnd sat sent_cnt", 64'(s_sent_cnt), 64'(sat(total, 4)));
            check("rnd sat in_ready", 64'(s_in_ready), 64'(exp_ready));
            check("rnd sat out_valid", 64'(s_out_valid), 64'(sb.size() != 0));
            check("rnd sat busy", 64'(s_busy), 64'(sb.size() != 0));
            if (sb.size() != 0) begin
                check("rnd out_data", 64'(out_data), 64'(sb[0].data));
                check("rnd out_lane", 64'(out_lane), 64'(sb[0].lane));
                check("rnd out_last", 64'(out_last), 64'(sb[0].last));
                check("rnd sat out_data", 64'(s_out_data), 64'(sb[0].data));
                check("rnd sat out_lane", 64'(s_out_lane), 64'(sb[0].lane));
                check("rnd sat out_last", 64'(s_out_last), 64'(sb[0].last));
                if (out_ready) begin
                    void'(sb.pop_front());
                    total++;
                end
            end
            if (in_valid && exp_ready) begin
                push_vec(in_vec, in_mask);
                pend = 1'b0;
            end else begin
                pend = in_valid;
            end
            @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
